// File: rtl/change_dispenser.sv
// Greedy coin dispenser: breaks a change amount into coins, largest first,
// and hands them one at a time to the coin ejector over a valid/ready handshake.
module change_dispenser #(
    parameter int N  = 7,
    parameter int D0 = 10,
    parameter int D1 = 5,
    parameter int D2 = 2,
    parameter int D3 = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] change_in,
    input  logic         abort,
    input  logic         coin_ready,
    output logic         coin_valid,
    output logic [1:0]   coin_type,
    output logic         busy,
    output logic         done,
    output logic         aborted,
    output logic [N-1:0] remaining,
    output logic [N-1:0] cnt0,
    output logic [N-1:0] cnt1,
    output logic [N-1:0] cnt2,
    output logic [N-1:0] cnt3,
    output logic [N-1:0] total_coins
);

    localparam logic [N-1:0] DEN0 = N'(D0);
    localparam logic [N-1:0] DEN1 = N'(D1);
    localparam logic [N-1:0] DEN2 = N'(D2);
    localparam logic [N-1:0] DEN3 = N'(D3);
    localparam logic [N-1:0] ONE  = N'(1);
    localparam logic [N-1:0] ZERO = N'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    logic [1:0] sel_idx;

    function automatic logic [N-1:0] denom(input logic [1:0] idx);
        case (idx)
            2'd0:    denom = DEN0;
            2'd1:    denom = DEN1;
            2'd2:    denom = DEN2;
            default: denom = DEN3;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort only matters while a coin sequence is in flight.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (change_in == ZERO) ? DONE : SELECT;
                end else begin
                    next_state = IDLE;
                end
            end
            SELECT: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (remaining == ZERO) begin
                    next_state = DONE;
                end else begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (coin_ready) begin
                    next_state = SELECT;
                end else begin
                    next_state = ISSUE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Greedy pick: lowest index whose denomination still fits.
    always_comb begin
        sel_idx = 2'd3;
        if (remaining >= DEN0) begin
            sel_idx = 2'd0;
        end else if (remaining >= DEN1) begin
            sel_idx = 2'd1;
        end else if (remaining >= DEN2) begin
            sel_idx = 2'd2;
        end else begin
            sel_idx = 2'd3;
        end
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coin_valid  <= 1'b0;
            coin_type   <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            remaining   <= ZERO;
            cnt0        <= ZERO;
            cnt1        <= ZERO;
            cnt2        <= ZERO;
            cnt3        <= ZERO;
            total_coins <= ZERO;
        end else begin
            busy    <= (next_state != IDLE);
            done    <= (next_state == DONE);
            aborted <= abort && ((state == SELECT) || (state == ISSUE));
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining   <= change_in;
                        cnt0        <= ZERO;
                        cnt1        <= ZERO;
                        cnt2        <= ZERO;
                        cnt3        <= ZERO;
                        total_coins <= ZERO;
                    end
                end
                SELECT: begin
                    if (!abort && (remaining != ZERO)) begin
                        coin_type  <= sel_idx;
                        coin_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Abort beats a simultaneous acceptance: the coin is not counted.
                    if (abort) begin
                        coin_valid <= 1'b0;
                    end else if (coin_ready) begin
                        coin_valid  <= 1'b0;
                        remaining   <= remaining - denom(coin_type);
                        total_coins <= total_coins + ONE;
                        case (coin_type)
                            2'd0:    cnt0 <= cnt0 + ONE;
                            2'd1:    cnt1 <= cnt1 + ONE;
                            2'd2:    cnt2 <= cnt2 + ONE;
                            default: cnt3 <= cnt3 + ONE;
                        endcase
                    end
                end
                DONE: begin
                    coin_valid <= 1'b0;
                end
                default: begin
                    coin_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
